// File: rtl/uart_frame_feeder_if.sv
// Handshake bundle between the frame feeder, the pixel-byte FIFO and the UART TX.
// The master modport is the feeder; the slave modport is whatever drives the FIFO/UART side.
interface uart_frame_feeder_if #(
   parameter int CNT_W = 24
);
   logic             i_start;
   logic             o_fifo_rd_en;
   logic [7:0]       i_fifo_rd_data;
   logic             i_fifo_empty;
   logic             o_Tx_Dv;
   logic [7:0]       o_Tx_Byte;
   logic             i_Tx_Done;
   logic             o_busy;
   logic             o_frame_done;
   logic [CNT_W-1:0] o_byte_count;

   modport master (
      input  i_start, i_fifo_rd_data, i_fifo_empty, i_Tx_Done,
      output o_fifo_rd_en, o_Tx_Dv, o_Tx_Byte, o_busy, o_frame_done, o_byte_count
   );

   modport slave (
      output i_start, i_fifo_rd_data, i_fifo_empty, i_Tx_Done,
      input  o_fifo_rd_en, o_Tx_Dv, o_Tx_Byte, o_busy, o_frame_done, o_byte_count
   );
endinterface

// File: rtl/uart_frame_feeder.sv
// Drains one frame from the pixel FIFO into the UART TX: 4 sync bytes, then FRAME_BYTES payload.
// Define UART_FRAME_FEEDER_CHECKSUM_EN to append an XOR checksum byte after the payload.
module uart_frame_feeder #(
   parameter int          FRAME_BYTES = 153600,
   parameter int          CNT_W       = 24,
   parameter logic [31:0] SYNC_WORD   = 32'hFFAA_55FF
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_frame_feeder_if.master bus
);

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BYTES);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_FETCH, S_LATCH, S_SEND, S_WAIT_DONE, S_WAIT_IDLE, S_FIN
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             hdr_q, hdr_d;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
   logic [7:0]       xor_q, xor_d;
   logic             csum_q, csum_d;
`endif

   function automatic logic [7:0] sync_byte(input logic [1:0] idx);
      logic [1:0] sel;
      sel = 2'd3 - idx;
      return SYNC_WORD[{sel, 3'b000} +: 8];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Each WAIT_IDLE exit happens only once the UART has dropped done, so the next Dv is safe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (bus.i_start) state_d = S_HDR;
         S_HDR:       state_d = S_WAIT_DONE;
         S_FETCH:     if (!bus.i_fifo_empty) state_d = S_LATCH;
         S_LATCH:     state_d = S_SEND;
         S_SEND:      state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (bus.i_Tx_Done) state_d = S_WAIT_IDLE;
         S_WAIT_IDLE: begin
            if (!bus.i_Tx_Done) begin
               if (hdr_q)                 state_d = (idx_q == 2'd3) ? S_FETCH : S_HDR;
               else if (cnt_q < FRAME_CNT) state_d = S_FETCH;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
               else if (!csum_q)          state_d = S_CSUM;
`endif
               else                       state_d = S_FIN;
            end
         end
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
         S_CSUM:      state_d = S_WAIT_DONE;
`endif
         S_FIN:       state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_d = byte_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      hdr_d  = hdr_q;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      xor_d  = xor_q;
      csum_d = csum_q;
`endif
      if (state_q == S_IDLE && bus.i_start) begin
         cnt_d  = '0;
         idx_d  = 2'd0;
         hdr_d  = 1'b1;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
         xor_d  = 8'h00;
         csum_d = 1'b0;
`endif
      end
      if (state_q == S_LATCH) begin
         byte_d = bus.i_fifo_rd_data;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
         xor_d  = xor_q ^ bus.i_fifo_rd_data;
`endif
      end
      if (state_q == S_SEND) cnt_d = cnt_q + 1'b1;
      if (state_q == S_WAIT_IDLE && state_d == S_HDR)   idx_d = idx_q + 2'd1;
      if (state_q == S_WAIT_IDLE && state_d == S_FETCH) hdr_d = 1'b0;
      // Header and checksum bytes are loaded on entry so they are valid in the Dv cycle.
      if (state_d == S_HDR) byte_d = sync_byte(idx_d);
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      if (state_d == S_CSUM) begin
         byte_d = xor_q;
         csum_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_q <= 8'h00;
         cnt_q  <= '0;
         idx_q  <= 2'd0;
         hdr_q  <= 1'b0;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
         xor_q  <= 8'h00;
         csum_q <= 1'b0;
`endif
      end else begin
         byte_q <= byte_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         hdr_q  <= hdr_d;
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
         xor_q  <= xor_d;
         csum_q <= csum_d;
`endif
      end
   end

   always_comb begin
      bus.o_fifo_rd_en = (state_q == S_FETCH) && !bus.i_fifo_empty;
      bus.o_Tx_Dv      = (state_q == S_HDR) || (state_q == S_SEND);
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      if (state_q == S_CSUM) bus.o_Tx_Dv = 1'b1;
`endif
      bus.o_busy       = (state_q != S_IDLE);
      bus.o_frame_done = (state_q == S_FIN);
      bus.o_Tx_Byte    = byte_q;
      bus.o_byte_count = cnt_q;
   end

endmodule

// File: tb/tb_uart_frame_feeder.sv
// Bench for uart_frame_feeder: FIFO and UART TX models, a byte-stream model and a per-cycle checker.
module tb_uart_frame_feeder;
   localparam int FB           = 4;
   localparam int CNT_W        = 24;
   localparam int CLKS_PER_BIT = 4;
   localparam int TX_CYCLES    = 10 * CLKS_PER_BIT + 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_frame_feeder_if #(.CNT_W(CNT_W)) ifc ();

   uart_frame_feeder #(.FRAME_BYTES(FB), .CNT_W(CNT_W), .SYNC_WORD(32'hFFAA_55FF)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // UART TX: busy for 10 bit times after Dv, then done high for the final 2 cycles.
   int tx_cnt = 0;
   always @(posedge clk) begin
      if (ifc.o_Tx_Dv && tx_cnt == 0) tx_cnt <= TX_CYCLES;
      else if (tx_cnt > 0)            tx_cnt <= tx_cnt - 1;
   end
   assign ifc.i_Tx_Done = (tx_cnt == 1) || (tx_cnt == 2);

   // FIFO with 1-cycle read latency.
   logic [7:0] fifo_mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign ifc.i_fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (ifc.o_fifo_rd_en && wr_ptr != rd_ptr) begin
         ifc.i_fifo_rd_data <= fifo_mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic fifo_push(input logic [7:0] b);
      fifo_mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   // Expected byte stream of a frame: sync word MSB first, payload, optional XOR of payload.
   logic [7:0] exp_q[$];
   task automatic expect_frame(input logic [31:0] pay);
      logic [31:0] sync;
      logic [7:0]  x;
      sync = 32'hFFAA_55FF;
      x    = 8'h00;
      for (int i = 0; i < 4; i++) exp_q.push_back(sync[31 - 8*i -: 8]);
      for (int i = 0; i < FB; i++) begin
         exp_q.push_back(pay[31 - 8*i -: 8]);
         x = x ^ pay[31 - 8*i -: 8];
      end
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   logic [7:0] sent [0:255];
   int n_sent = 0, dv_total = 0, rd_total = 0, done_total = 0;
   int frame_dv = 0;
   int model_cnt = 0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         model_cnt = 0;
         frame_dv  = 0;
         prev_busy = 1'b0;
      end else begin
         if (ifc.o_busy && !prev_busy) begin
            model_cnt = 0;
            frame_dv  = 0;
         end
         prev_busy = ifc.o_busy;
         if (ifc.o_busy) chk("byte_count", ifc.o_byte_count, model_cnt);
         if (ifc.o_fifo_rd_en) begin
            rd_total++;
            chk("rd_while_empty", ifc.i_fifo_empty, 0);
         end
         if (ifc.o_frame_done) done_total++;
         if (ifc.o_Tx_Dv) begin
            dv_total++;
            chk("dv_while_done", ifc.i_Tx_Done, 0);
            chk("dv_outstanding", tx_cnt == 0, 1);
            chk("dv_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_byte", ifc.o_Tx_Byte, exp_q.pop_front());
            sent[n_sent] = ifc.o_Tx_Byte;
            n_sent++;
            if (frame_dv >= 4 && frame_dv < 4 + FB) model_cnt++;
            frame_dv++;
         end
      end
   end

   task automatic start_frame();
      @(negedge clk);
      ifc.i_start = 1'b1;
      @(negedge clk);
      ifc.i_start = 1'b0;
      chk("start_to_dv", ifc.o_Tx_Dv, 1);
   endtask

   task automatic wait_frame(input int base);
      int n = 0;
      while (done_total == base && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("frame_timeout", done_total != base, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, ifc.o_fifo_rd_en, 0);
      chk({tag, "_dv"}, ifc.o_Tx_Dv, 0);
      chk({tag, "_byte"}, ifc.o_Tx_Byte, 0);
      chk({tag, "_busy"}, ifc.o_busy, 0);
      chk({tag, "_done"}, ifc.o_frame_done, 0);
      chk({tag, "_count"}, ifc.o_byte_count, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, d, r, n, snap_dv, snap_rd;
      rst_n = 1'b0;
      ifc.i_start = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;

      // Plain frame
      b = n_sent; d = done_total; r = rd_total;
      fifo_push(8'h12); fifo_push(8'h34); fifo_push(8'h56); fifo_push(8'h78);
      expect_frame(32'h1234_5678);
      start_frame();
      wait_frame(d);
      chk("f1_hdr0", sent[b], 8'hFF);
      chk("f1_hdr1", sent[b+1], 8'hAA);
      chk("f1_hdr2", sent[b+2], 8'h55);
      chk("f1_hdr3", sent[b+3], 8'hFF);
      chk("f1_pay0", sent[b+4], 8'h12);
      chk("f1_pay3", sent[b+7], 8'h78);
`ifdef UART_FRAME_FEEDER_CHECKSUM_EN
      chk("f1_csum", sent[b+8], 8'h08);
`endif
      chk("f1_reads", rd_total - r, 4);
      chk("f1_done_pulses", done_total - d, 1);
      chk("f1_count", ifc.o_byte_count, 4);
      chk("f1_busy", ifc.o_busy, 0);
      chk("f1_drained", exp_q.size(), 0);

      // FIFO runs dry after two payload bytes
      d = done_total; r = rd_total;
      fifo_push(8'hA1); fifo_push(8'hB2);
      expect_frame(32'hA1B2_C3D4);
      start_frame();
      n = 0;
      while (rd_total < r + 2 && n < 2000) begin @(posedge clk); n++; end
      chk("stall_reach", rd_total - r, 2);
      repeat (100) @(negedge clk);
      snap_dv = dv_total; snap_rd = rd_total;
      repeat (400) @(negedge clk);
      chk("stall_dv", dv_total, snap_dv);
      chk("stall_rd", rd_total, snap_rd);
      chk("stall_busy", ifc.o_busy, 1);
      chk("stall_count", ifc.o_byte_count, 2);
      fifo_push(8'hC3); fifo_push(8'hD4);
      wait_frame(d);
      chk("stall_reads", rd_total - r, 4);
      chk("stall_count_end", ifc.o_byte_count, 4);
      chk("stall_drained", exp_q.size(), 0);

      // Second start mid-frame is ignored
      d = done_total; r = rd_total;
      fifo_push(8'h9C); fifo_push(8'h00); fifo_push(8'hFF); fifo_push(8'h3E);
      expect_frame(32'h9C00_FF3E);
      start_frame();
      repeat (60) @(negedge clk);
      ifc.i_start = 1'b1;
      @(negedge clk);
      ifc.i_start = 1'b0;
      wait_frame(d);
      repeat (100) @(negedge clk);
      chk("mid_done_pulses", done_total - d, 1);
      chk("mid_reads", rd_total - r, 4);
      chk("mid_busy", ifc.o_busy, 0);
      chk("mid_drained", exp_q.size(), 0);

      // Reset during the third payload byte
      d = done_total;
      fifo_push(8'h01); fifo_push(8'h02); fifo_push(8'h03); fifo_push(8'h04);
      expect_frame(32'h0102_0304);
      snap_dv = dv_total;
      start_frame();
      n = 0;
      while (dv_total < snap_dv + 7 && n < 2000) begin @(posedge clk); n++; end
      chk("rst_reach", dv_total - snap_dv, 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      wr_ptr = rd_ptr;
      n = 0;
      while (tx_cnt != 0 && n < 200) begin @(negedge clk); n++; end
      chk("uart_settle", tx_cnt, 0);
      chk("rst_no_done", done_total - d, 0);
      b = n_sent; r = rd_total;
      fifo_push(8'h5A); fifo_push(8'hA5); fifo_push(8'h11); fifo_push(8'hEE);
      expect_frame(32'h5AA5_11EE);
      start_frame();
      wait_frame(d);
      chk("post_hdr0", sent[b], 8'hFF);
      chk("post_hdr1", sent[b+1], 8'hAA);
      chk("post_hdr2", sent[b+2], 8'h55);
      chk("post_hdr3", sent[b+3], 8'hFF);
      chk("post_pay0", sent[b+4], 8'h5A);
      chk("post_reads", rd_total - r, 4);
      chk("post_count", ifc.o_byte_count, 4);
      chk("post_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
